ccu_snoop_arbiter: RTL and testbench

Shares one snoop-crossbar port (AC/CR/CD) among NumReq CCU snoop controllers, for example the read-snoop and write-snoop FSMs. AC requests are arbitrated round-robin and forwarded downstream. The requester index of each accepted snoop is remembered in order, so that CR responses, and any CD data bursts, are steered back to the requester that issued the snoop. The block sits between the CCU controllers and the snoop crossbar; it never generates or modifies snoops.

---
 rtl/ccu_snoop_arbiter_pkg.sv | 16 +
 rtl/ccu_snoop_arbiter_idx_fifo.sv | 69 ++++++
 rtl/ccu_snoop_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ccu_snoop_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccu_snoop_arbiter_pkg.sv
// Shared constants and helpers for the CCU snoop-port arbiter.
package ccu_snoop_arbiter_pkg;

  // CRRESP bit positions
  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  // Width of a requester index; at least one bit so a single requester still has a legal vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ccu_snoop_arbiter_idx_fifo.sv
// Counter-based FIFO of requester indices. Used to remember which requester owns each in-flight
// CR and CD. Push and pop may happen in the same cycle, including when the FIFO is full.
// A pushed entry becomes visible at the head only from the next cycle.
module ccu_idx_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  usage_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside a pop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | pop_i);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ccu_snoop_arbiter.sv
// Shares one snoop-crossbar port among NumReq CCU snoop controllers. AC is arbitrated
// round-robin; CR and CD are steered back to the issuer using in-order index FIFOs.
module ccu_snoop_arbiter
  import ccu_snoop_arbiter_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_ac_valid_i,
  output logic [NumReq-1:0]                    req_ac_ready_o,
  input  logic [NumReq*AddrWidth-1:0]          req_ac_addr_i,
  input  logic [NumReq*4-1:0]                  req_ac_snoop_i,
  input  logic [NumReq*3-1:0]                  req_ac_prot_i,
  output logic [NumReq-1:0]                    req_cr_valid_o,
  input  logic [NumReq-1:0]                    req_cr_ready_i,
  output logic [4:0]                           req_cr_resp_o,
  output logic [NumReq-1:0]                    req_cd_valid_o,
  input  logic [NumReq-1:0]                    req_cd_ready_i,
  output logic [DataWidth-1:0]                 req_cd_data_o,
  output logic                                 req_cd_last_o,
  output logic                                 snp_ac_valid_o,
  input  logic                                 snp_ac_ready_i,
  output logic [AddrWidth-1:0]                 snp_ac_addr_o,
  output logic [3:0]                           snp_ac_snoop_o,
  output logic [2:0]                           snp_ac_prot_o,
  input  logic                                 snp_cr_valid_i,
  output logic                                 snp_cr_ready_o,
  input  logic [4:0]                           snp_cr_resp_i,
  input  logic                                 snp_cd_valid_i,
  output logic                                 snp_cd_ready_o,
  input  logic [DataWidth-1:0]                 snp_cd_data_i,
  input  logic                                 snp_cd_last_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
);

  localparam int unsigned IdxW = idx_width(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d, lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] arb_idx, cand, grant, cr_head, cd_head;
  logic            arb_found, any_valid, ac_hs;
  logic            cr_full, cr_empty, cd_full, cd_empty;
  logic            cr_hs, cd_push, cd_pop, sel_cr_ready, sel_cd_ready;
  logic [CntW-1:0] cr_usage, cd_usage_unused;

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_ptr_q;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((rr_ptr_q + i) % NumReq);
      if (!arb_found && req_ac_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A stalled AC keeps its registered grant so downstream sees stable fields.
  assign grant     = lock_q ? lock_idx_q : arb_idx;
  assign any_valid = |req_ac_valid_i;
  // Gated by reset so every valid output drops immediately, even with requesters still asserting.
  assign snp_ac_valid_o = ~rst_i & any_valid & ~cr_full;
  assign ac_hs          = snp_ac_valid_o & snp_ac_ready_i;

  // Zero-latency AC mux and ready return to the granted requester.
  always_comb begin
    snp_ac_addr_o  = '0;
    snp_ac_snoop_o = '0;
    snp_ac_prot_o  = '0;
    req_ac_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (grant == IdxW'(i)) begin
        snp_ac_addr_o     = req_ac_addr_i[i*AddrWidth +: AddrWidth];
        snp_ac_snoop_o    = req_ac_snoop_i[i*4 +: 4];
        snp_ac_prot_o     = req_ac_prot_i[i*3 +: 3];
        req_ac_ready_o[i] = snp_ac_valid_o & snp_ac_ready_i;
      end
    end
  end

  // Pointer advance on handshake; grant lock while AC is stalled.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (ac_hs) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant == IdxW'(NumReq - 1)) ? '0 : grant + IdxW'(1);
    end else if (snp_ac_valid_o) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  ccu_idx_fifo #(.Width(IdxW), .Depth(MaxOutstanding)) u_cr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ac_hs),
    .data_i  (grant),
    .pop_i   (cr_hs),
    .data_o  (cr_head),
    .full_o  (cr_full),
    .empty_o (cr_empty),
    .usage_o (cr_usage)
  );

  ccu_idx_fifo #(.Width(IdxW), .Depth(MaxOutstanding)) u_cd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (cd_push),
    .data_i  (cr_head),
    .pop_i   (cd_pop),
    .data_o  (cd_head),
    .full_o  (cd_full),
    .empty_o (cd_empty),
    .usage_o (cd_usage_unused)
  );

  // CR steering to the oldest outstanding issuer.
  always_comb begin
    req_cr_valid_o = '0;
    sel_cr_ready   = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (cr_head == IdxW'(i)) begin
        req_cr_valid_o[i] = snp_cr_valid_i & ~cr_empty;
        sel_cr_ready      = req_cr_ready_i[i];
      end
    end
  end

  // A CR carrying DataTransfer needs a CD slot, so CR stalls while the CD FIFO is full.
  assign snp_cr_ready_o = ~cr_empty & sel_cr_ready & ~cd_full;
  assign cr_hs          = snp_cr_valid_i & snp_cr_ready_o;
  assign cd_push        = cr_hs & snp_cr_resp_i[CrDataTransfer];
  assign req_cr_resp_o  = snp_cr_resp_i;

  // CD steering to the owner of the oldest pending data burst.
  always_comb begin
    req_cd_valid_o = '0;
    sel_cd_ready   = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (cd_head == IdxW'(i)) begin
        req_cd_valid_o[i] = snp_cd_valid_i & ~cd_empty;
        sel_cd_ready      = req_cd_ready_i[i];
      end
    end
  end

  assign snp_cd_ready_o = ~cd_empty & sel_cd_ready;
  assign cd_pop         = snp_cd_valid_i & snp_cd_ready_o & snp_cd_last_i;
  assign req_cd_data_o  = snp_cd_data_i;
  assign req_cd_last_o  = snp_cd_last_i;
  assign outstanding_o  = cr_usage;

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Self-checking bench for ccu_snoop_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_ccu_snoop_arbiter;

  localparam int N  = 2;
  localparam int MO = 4;
  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [N-1:0]    req_ac_valid_i = '0;
  logic [N-1:0]    req_ac_ready_o;
  logic [N*AW-1:0] req_ac_addr_i = '0;
  logic [N*4-1:0]  req_ac_snoop_i = '0;
  logic [N*3-1:0]  req_ac_prot_i = '0;
  logic [N-1:0]    req_cr_valid_o;
  logic [N-1:0]    req_cr_ready_i = '0;
  logic [4:0]      req_cr_resp_o;
  logic [N-1:0]    req_cd_valid_o;
  logic [N-1:0]    req_cd_ready_i = '0;
  logic [DW-1:0]   req_cd_data_o;
  logic            req_cd_last_o;
  logic            snp_ac_valid_o;
  logic            snp_ac_ready_i = 1'b0;
  logic [AW-1:0]   snp_ac_addr_o;
  logic [3:0]      snp_ac_snoop_o;
  logic [2:0]      snp_ac_prot_o;
  logic            snp_cr_valid_i = 1'b0;
  logic            snp_cr_ready_o;
  logic [4:0]      snp_cr_resp_i = '0;
  logic            snp_cd_valid_i = 1'b0;
  logic            snp_cd_ready_o;
  logic [DW-1:0]   snp_cd_data_i = '0;
  logic            snp_cd_last_i = 1'b0;
  logic [2:0]      outstanding_o;

  int checks = 0;
  int failures = 0;

  ccu_snoop_arbiter #(.NumReq(N), .MaxOutstanding(MO), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_ac_valid_i(req_ac_valid_i), .req_ac_ready_o(req_ac_ready_o),
    .req_ac_addr_i(req_ac_addr_i), .req_ac_snoop_i(req_ac_snoop_i), .req_ac_prot_i(req_ac_prot_i),
    .req_cr_valid_o(req_cr_valid_o), .req_cr_ready_i(req_cr_ready_i), .req_cr_resp_o(req_cr_resp_o),
    .req_cd_valid_o(req_cd_valid_o), .req_cd_ready_i(req_cd_ready_i),
    .req_cd_data_o(req_cd_data_o), .req_cd_last_o(req_cd_last_o),
    .snp_ac_valid_o(snp_ac_valid_o), .snp_ac_ready_i(snp_ac_ready_i), .snp_ac_addr_o(snp_ac_addr_o),
    .snp_ac_snoop_o(snp_ac_snoop_o), .snp_ac_prot_o(snp_ac_prot_o),
    .snp_cr_valid_i(snp_cr_valid_i), .snp_cr_ready_o(snp_cr_ready_o), .snp_cr_resp_i(snp_cr_resp_i),
    .snp_cd_valid_i(snp_cd_valid_i), .snp_cd_ready_o(snp_cd_ready_o), .snp_cd_data_i(snp_cd_data_i),
    .snp_cd_last_i(snp_cd_last_i), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] acv; logic acr; logic crv; logic [4:0] resp; logic [1:0] crr;
    logic cdv; logic cdl; logic [1:0] cdr;
    logic e_acv; logic [1:0] e_ardy; int e_gnt; logic [1:0] e_crv; logic e_crrdy;
    logic [1:0] e_cdv; logic e_cdrdy; int e_out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [1:0] acv, logic acr, logic crv, logic [4:0] resp, logic [1:0] crr,
                             logic cdv, logic cdl, logic [1:0] cdr,
                             logic e_acv, logic [1:0] e_ardy, int e_gnt, logic [1:0] e_crv, logic e_crrdy,
                             logic [1:0] e_cdv, logic e_cdrdy, int e_out);
    vec_t r;
    r.acv = acv; r.acr = acr; r.crv = crv; r.resp = resp; r.crr = crr;
    r.cdv = cdv; r.cdl = cdl; r.cdr = cdr;
    r.e_acv = e_acv; r.e_ardy = e_ardy; r.e_gnt = e_gnt; r.e_crv = e_crv; r.e_crrdy = e_crrdy;
    r.e_cdv = e_cdv; r.e_cdrdy = e_cdrdy; r.e_out = e_out;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [1:0] acv, logic acr, logic crv, logic [4:0] resp, logic [1:0] crr,
                       logic cdv, logic cdl, logic [1:0] cdr);
    req_ac_valid_i = acv; snp_ac_ready_i = acr;
    snp_cr_valid_i = crv; snp_cr_resp_i = resp; req_cr_ready_i = crr;
    snp_cd_valid_i = cdv; snp_cd_last_i = cdl; req_cd_ready_i = cdr;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] fixed_addr(int g);
    return (g == 0) ? 64'h1000 : 64'h2000;
  endfunction

  // Reference-model state: ordered owner queues, pointer, held grant.
  int crq[$];
  int cdq[$];
  int m_ptr;
  bit m_lock;
  int m_lock_idx;

  initial begin
    req_ac_addr_i  = {64'h2000, 64'h1000};
    req_ac_snoop_i = {4'h7, 4'h7};
    req_ac_prot_i  = '0;

    // Reset state
    @(posedge clk_i); @(posedge clk_i); #1;
    check("rst_ac_valid", snp_ac_valid_o, 0);
    check("rst_ac_ready", req_ac_ready_o, 0);
    check("rst_cr_valid", req_cr_valid_o, 0);
    check("rst_cr_ready", snp_cr_ready_o, 0);
    check("rst_cd_valid", req_cd_valid_o, 0);
    check("rst_cd_ready", snp_cd_ready_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    rst_i = 1'b0;
    next_cycle();

    // Directed vector table
    vecs.push_back(v(2'b01,1, 0,5'h00,2'b00, 0,0,2'b00, 1,2'b01,0, 2'b00,0, 2'b00,0, 0));
    vecs.push_back(v(2'b00,0, 1,5'h00,2'b01, 0,0,2'b00, 0,2'b00,0, 2'b01,1, 2'b00,0, 1));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 0,0,2'b00, 0,2'b00,0, 2'b00,0, 2'b00,0, 0));
    vecs.push_back(v(2'b11,1, 0,5'h00,2'b00, 0,0,2'b00, 1,2'b10,1, 2'b00,0, 2'b00,0, 0));
    vecs.push_back(v(2'b11,1, 0,5'h00,2'b00, 0,0,2'b00, 1,2'b01,0, 2'b00,0, 2'b00,0, 1));
    vecs.push_back(v(2'b11,1, 0,5'h00,2'b00, 0,0,2'b00, 1,2'b10,1, 2'b00,0, 2'b00,0, 2));
    vecs.push_back(v(2'b11,1, 0,5'h00,2'b00, 0,0,2'b00, 1,2'b01,0, 2'b00,0, 2'b00,0, 3));
    vecs.push_back(v(2'b11,1, 1,5'h01,2'b10, 0,0,2'b00, 0,2'b00,0, 2'b10,1, 2'b00,0, 4));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 1,0,2'b10, 0,2'b00,0, 2'b00,0, 2'b10,1, 3));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 1,0,2'b00, 0,2'b00,0, 2'b00,0, 2'b10,0, 3));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 1,1,2'b10, 0,2'b00,0, 2'b00,0, 2'b10,1, 3));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 1,0,2'b11, 0,2'b00,0, 2'b00,0, 2'b00,0, 3));
    vecs.push_back(v(2'b00,0, 1,5'h03,2'b01, 0,0,2'b00, 0,2'b00,0, 2'b01,1, 2'b00,0, 3));
    vecs.push_back(v(2'b00,0, 1,5'h00,2'b00, 1,0,2'b01, 0,2'b00,0, 2'b10,0, 2'b01,1, 2));
    vecs.push_back(v(2'b00,0, 1,5'h00,2'b10, 1,1,2'b01, 0,2'b00,0, 2'b10,1, 2'b01,1, 2));
    vecs.push_back(v(2'b00,0, 1,5'h00,2'b01, 0,0,2'b00, 0,2'b00,0, 2'b01,1, 2'b00,0, 1));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 0,0,2'b00, 0,2'b00,0, 2'b00,0, 2'b00,0, 0));
    vecs.push_back(v(2'b10,1, 0,5'h00,2'b00, 0,0,2'b00, 1,2'b10,1, 2'b00,0, 2'b00,0, 0));
    vecs.push_back(v(2'b01,1, 0,5'h00,2'b00, 0,0,2'b00, 1,2'b01,0, 2'b00,0, 2'b00,0, 1));
    vecs.push_back(v(2'b00,0, 1,5'h01,2'b11, 0,0,2'b00, 0,2'b00,0, 2'b10,1, 2'b00,0, 2));
    vecs.push_back(v(2'b00,0, 1,5'h00,2'b11, 1,0,2'b11, 0,2'b00,0, 2'b01,1, 2'b10,1, 1));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 1,0,2'b11, 0,2'b00,0, 2'b00,0, 2'b10,1, 0));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 1,0,2'b11, 0,2'b00,0, 2'b00,0, 2'b10,1, 0));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 1,1,2'b11, 0,2'b00,0, 2'b00,0, 2'b10,1, 0));
    vecs.push_back(v(2'b00,0, 0,5'h00,2'b00, 0,0,2'b00, 0,2'b00,0, 2'b00,0, 2'b00,0, 0));

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].acv, vecs[r].acr, vecs[r].crv, vecs[r].resp, vecs[r].crr,
            vecs[r].cdv, vecs[r].cdl, vecs[r].cdr);
      #3;
      check($sformatf("row%0d_ac_valid", r), snp_ac_valid_o, vecs[r].e_acv);
      check($sformatf("row%0d_ac_ready", r), req_ac_ready_o, vecs[r].e_ardy);
      if (vecs[r].e_acv)
        check($sformatf("row%0d_ac_addr", r), snp_ac_addr_o, fixed_addr(vecs[r].e_gnt));
      check($sformatf("row%0d_cr_valid", r), req_cr_valid_o, vecs[r].e_crv);
      check($sformatf("row%0d_cr_ready", r), snp_cr_ready_o, vecs[r].e_crrdy);
      check($sformatf("row%0d_cd_valid", r), req_cd_valid_o, vecs[r].e_cdv);
      check($sformatf("row%0d_cd_ready", r), snp_cd_ready_o, vecs[r].e_cdrdy);
      check($sformatf("row%0d_outstanding", r), outstanding_o, vecs[r].e_out);
      next_cycle();
    end

    // Grant lock: move the pointer to 0, then stall req1 and let req0 (now higher priority) arrive.
    drive(2'b10, 1, 0, 5'h00, 2'b00, 0, 0, 2'b00);
    #3; check("lock_pre_ready", req_ac_ready_o, 2'b10);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 0, 0, 5'h00, 2'b00, 0, 0, 2'b00);
      #3; check($sformatf("lock_stall%0d_addr", k), snp_ac_addr_o, 64'h2000);
      next_cycle();
    end
    drive(2'b11, 0, 0, 5'h00, 2'b00, 0, 0, 2'b00);
    #3;
    check("lock_hold_addr", snp_ac_addr_o, 64'h2000);
    check("lock_hold_ready", req_ac_ready_o, 2'b00);
    next_cycle();
    drive(2'b11, 1, 0, 5'h00, 2'b00, 0, 0, 2'b00);
    #3;
    check("lock_hs_addr", snp_ac_addr_o, 64'h2000);
    check("lock_hs_ready", req_ac_ready_o, 2'b10);
    next_cycle();
    drive(2'b01, 1, 0, 5'h00, 2'b00, 0, 0, 2'b00);
    #3;
    check("lock_after_addr", snp_ac_addr_o, 64'h1000);
    check("lock_after_ready", req_ac_ready_o, 2'b01);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 0, 1, 5'h00, 2'b11, 0, 0, 2'b00);
      #3;
      check($sformatf("lock_drain%0d_out", k), outstanding_o, 3 - k);
      check($sformatf("lock_drain%0d_cr_valid", k), req_cr_valid_o, (k == 2) ? 2'b01 : 2'b10);
      next_cycle();
    end

    // Backpressure: four accepted ACs fill the CR FIFO, the fifth is blocked; then async reset.
    for (int k = 0; k < 4; k++) begin
      drive(2'b01, 1, 0, 5'h00, 2'b00, 0, 0, 2'b00);
      #3;
      check($sformatf("bp%0d_ready", k), req_ac_ready_o, 2'b01);
      check($sformatf("bp%0d_out", k), outstanding_o, k);
      next_cycle();
    end
    drive(2'b01, 1, 1, 5'h00, 2'b00, 0, 0, 2'b00);
    #3;
    check("bp_full_ready", req_ac_ready_o, 2'b00);
    check("bp_full_valid", snp_ac_valid_o, 0);
    check("bp_full_out", outstanding_o, 4);
    check("bp_full_cr_valid", req_cr_valid_o, 2'b01);
    rst_i = 1'b1;
    #1;
    check("arst_out", outstanding_o, 0);
    check("arst_ac_valid", snp_ac_valid_o, 0);
    check("arst_ac_ready", req_ac_ready_o, 2'b00);
    check("arst_cr_valid", req_cr_valid_o, 2'b00);
    check("arst_cd_valid", req_cd_valid_o, 2'b00);
    next_cycle();
    drive(2'b00, 0, 0, 5'h00, 2'b00, 0, 0, 2'b00);
    rst_i = 1'b0;
    next_cycle();

    // Randomized traffic against the queue model.
    crq.delete(); cdq.delete();
    m_ptr = 0; m_lock = 0; m_lock_idx = 0;
    begin
      logic [1:0] ac_done;
      logic cr_done, cd_done;
      ac_done = '0; cr_done = 0; cd_done = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        int g;
        bit any, full, e_acv, ac_hs, cr_hs, cd_hs, e_crrdy, e_cdrdy;
        logic [1:0] e_ardy, e_crv, e_cdv;
        logic [63:0] e_addr;
        logic [3:0] e_snoop;
        logic [2:0] e_prot;

        for (int i = 0; i < N; i++) begin
          if (ac_done[i]) req_ac_valid_i[i] = 1'b0;
          if (!req_ac_valid_i[i] && $urandom_range(0, 1) == 1) begin
            req_ac_valid_i[i] = 1'b1;
            req_ac_addr_i[i*AW +: AW] = {$urandom, $urandom};
            req_ac_snoop_i[i*4 +: 4]  = 4'($urandom);
            req_ac_prot_i[i*3 +: 3]   = 3'($urandom);
          end
        end
        if (cr_done) snp_cr_valid_i = 1'b0;
        if (!snp_cr_valid_i && crq.size() > 0 && $urandom_range(0, 1) == 1) begin
          snp_cr_valid_i = 1'b1;
          snp_cr_resp_i  = 5'($urandom);
        end
        if (cd_done) snp_cd_valid_i = 1'b0;
        if (!snp_cd_valid_i && cdq.size() > 0 && $urandom_range(0, 2) != 0) begin
          snp_cd_valid_i = 1'b1;
          snp_cd_data_i  = {$urandom, $urandom};
          snp_cd_last_i  = ($urandom_range(0, 2) == 0);
        end
        snp_ac_ready_i = ($urandom_range(0, 3) != 0);
        req_cr_ready_i = 2'($urandom);
        req_cd_ready_i = 2'($urandom);
        #3;

        any   = (req_ac_valid_i != 0);
        full  = (crq.size() >= MO);
        e_acv = any && !full;
        g = 0;
        if (m_lock) g = m_lock_idx;
        else begin
          for (int k = N - 1; k >= 0; k--)
            if (req_ac_valid_i[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        e_ardy  = (e_acv && snp_ac_ready_i) ? (2'b01 << g) : 2'b00;
        e_addr  = req_ac_addr_i[g*AW +: AW];
        e_snoop = req_ac_snoop_i[g*4 +: 4];
        e_prot  = req_ac_prot_i[g*3 +: 3];
        e_crv   = (crq.size() > 0 && snp_cr_valid_i) ? (2'b01 << crq[0]) : 2'b00;
        e_crrdy = (crq.size() > 0) && req_cr_ready_i[crq[0]] && (cdq.size() < MO);
        e_cdv   = (cdq.size() > 0 && snp_cd_valid_i) ? (2'b01 << cdq[0]) : 2'b00;
        e_cdrdy = (cdq.size() > 0) && req_cd_ready_i[cdq[0]];

        check("rnd_ac_valid", snp_ac_valid_o, e_acv);
        check("rnd_ac_ready", req_ac_ready_o, e_ardy);
        if (e_acv) begin
          check("rnd_ac_addr", snp_ac_addr_o, e_addr);
          check("rnd_ac_snoop", snp_ac_snoop_o, e_snoop);
          check("rnd_ac_prot", snp_ac_prot_o, e_prot);
        end
        check("rnd_cr_valid", req_cr_valid_o, e_crv);
        check("rnd_cr_ready", snp_cr_ready_o, e_crrdy);
        check("rnd_cr_resp", req_cr_resp_o, snp_cr_resp_i);
        check("rnd_cd_valid", req_cd_valid_o, e_cdv);
        check("rnd_cd_ready", snp_cd_ready_o, e_cdrdy);
        if (snp_cd_valid_i) begin
          check("rnd_cd_data", req_cd_data_o, snp_cd_data_i);
          check("rnd_cd_last", req_cd_last_o, snp_cd_last_i);
        end
        check("rnd_outstanding", outstanding_o, crq.size());

        ac_hs = e_acv && snp_ac_ready_i;
        cr_hs = snp_cr_valid_i && e_crrdy;
        cd_hs = snp_cd_valid_i && e_cdrdy;
        if (cr_hs) begin
          int h;
          h = crq.pop_front();
          if (snp_cr_resp_i[0]) cdq.push_back(h);
        end
        if (cd_hs && snp_cd_last_i) void'(cdq.pop_front());
        if (ac_hs) begin
          crq.push_back(g);
          m_ptr  = (g + 1) % N;
          m_lock = 0;
        end else if (e_acv) begin
          m_lock     = 1;
          m_lock_idx = g;
        end
        ac_done = ac_hs ? (2'b01 << g) : 2'b00;
        cr_done = cr_hs;
        cd_done = cd_hs;
        next_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
